// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor_filt_pkg.sv
// Shared definitions for the filtered multi-channel NOR.
// Holds the counter-width helper, the reset values of the filtered output and
// the synchroniser flops, and a legality check for the block parameters.
package gf180mcu_fd_sc_mcu7t5v0__nor_filt_pkg;

  // NOR of all-zero inputs is 1, so both the output and the synchroniser
  // come out of reset already agreeing with an idle input bus.
  localparam logic ZN_RST   = 1'b1;
  localparam logic SYNC_RST = 1'b1;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // DEPTH=1 needs no counting at all, but a zero-width vector is illegal,
  // so the counter is always at least one bit wide.
  function automatic int cnt_width(input int depth);
    return (clog2(depth) > 0) ? clog2(depth) : 1;
  endfunction

  function automatic bit params_legal(input int width, input int depth,
                                      input int sync_stages);
    return (width >= 2) && (depth >= 1) &&
           (sync_stages >= 0) && (sync_stages <= 3);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor_filt_chan.sv
// One channel of the filtered NOR: combinational NOR, optional synchroniser
// chain, then a glitch filter that only lets a new level through after it has
// been seen on DEPTH consecutive enabled clocks.
// Ports:
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   en           filter enable; low freezes the counter and zn
//   bypass       zn follows the synchronised NOR directly, no filtering
//   a            WIDTH NOR inputs for this channel
//   zn           filtered NOR output (registered)
//   zn_chg       one-cycle pulse in the cycle zn takes a new value
module gf180mcu_fd_sc_mcu7t5v0__nor_filt_chan
  import gf180mcu_fd_sc_mcu7t5v0__nor_filt_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             bypass,
  input  logic [WIDTH-1:0] a,
  output logic             zn,
  output logic             zn_chg
);

  localparam int            CW      = cnt_width(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH - 1);

  logic          raw;
  logic          s;
  logic [CW-1:0] cnt;

  assign raw = ~|a;

  // Synchroniser: with zero stages the raw NOR feeds the filter directly.
  // The chain keeps shifting regardless of en/bypass.
  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = raw;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= {SYNC_STAGES{SYNC_RST}};
      end else begin
        sync_q[0] <= raw;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // Glitch filter. cnt counts consecutive enabled edges on which s disagreed
  // with zn; any agreement clears it, so a short glitch earns no credit
  // towards the next one. Bypass overrides the enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zn     <= ZN_RST;
      zn_chg <= 1'b0;
      cnt    <= '0;
    end else if (bypass) begin
      zn     <= s;
      zn_chg <= (s != zn);
      cnt    <= '0;
    end else if (!en) begin
      zn_chg <= 1'b0;
    end else if (s == zn) begin
      zn_chg <= 1'b0;
      cnt    <= '0;
    end else if (cnt == CNT_MAX) begin
      zn     <= s;
      zn_chg <= 1'b1;
      cnt    <= '0;
    end else begin
      zn_chg <= 1'b0;
      cnt    <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nor_filt.sv
// Multi-channel NOR with per-channel synchroniser and glitch filter, for
// bringing asynchronous pad / wake-up signals into synchronous control logic.
// Ports:
//   CLK, RST   clock (rising edge) and asynchronous active-high reset
//   EN         filter enable; low freezes counters and ZN
//   BYPASS     ZN follows the synchronised NOR one cycle later, unfiltered
//   A          CHANNELS*WIDTH inputs; channel c uses A[c*WIDTH +: WIDTH]
//   ZN         filtered NOR per channel
//   ZN_CHG     one-cycle pulse per channel when its ZN changes
module gf180mcu_fd_sc_mcu7t5v0__nor_filt
  import gf180mcu_fd_sc_mcu7t5v0__nor_filt_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int CHANNELS    = 4,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      BYPASS,
  input  logic [CHANNELS*WIDTH-1:0] A,
  output logic [CHANNELS-1:0]       ZN,
  output logic [CHANNELS-1:0]       ZN_CHG
);

  // Refuse to elaborate with parameters the channel logic cannot honour.
  if (!params_legal(WIDTH, DEPTH, SYNC_STAGES) || (CHANNELS < 1)) begin : g_bad_params
    $error("nor_filt: illegal parameters WIDTH=%0d DEPTH=%0d SYNC_STAGES=%0d CHANNELS=%0d",
           WIDTH, DEPTH, SYNC_STAGES, CHANNELS);
  end

  // Channels are fully independent; each gets its own slice of A.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    gf180mcu_fd_sc_mcu7t5v0__nor_filt_chan #(
      .WIDTH       (WIDTH),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk    (CLK),
      .rst    (RST),
      .en     (EN),
      .bypass (BYPASS),
      .a      (A[c*WIDTH +: WIDTH]),
      .zn     (ZN[c]),
      .zn_chg (ZN_CHG[c])
    );
  end

endmodule
